microwave_timer: RTL and testbench
==================================

MICROWAVE_TIMER -- requirements
Module: microwave_timer

Interface
REQ-001 Parameter T_W, default 8, width of cook-time load value and countdown; legal range 2..16.
REQ-002 Parameter BELL_CYCLES, default 4, number of cycles the bell sounds before auto-return to CLOSED; legal range >= 1.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 nrst  input  1  reset, asynchronous assert and active-low.
REQ-005 door  input  1  1 = door open.
REQ-006 start  input  1  start request, level-sampled each cycle.
REQ-007 stop  input  1  cancel request, level-sampled each cycle.
REQ-008 time_in  input  T_W  cook time in cycles, sampled only on an accepted start.
REQ-009 power  input  2  heating duty level, sampled every COOK cycle.
REQ-010 bell  output  1  bell active.
REQ-011 light  output  1  cavity light on.
REQ-012 heat  output  1  magnetron on.
REQ-013 busy  output  1  1 while a cook job is active (COOK or PAUSE).
REQ-014 remaining  output  T_W  cycles of cook time left.

Function
REQ-015 States SHALL be CLOSED, COOK, PAUSE, BELL, OPEN, one-hot encoded.
REQ-016 All outputs SHALL decode from registered state and counters only; no combinational path from any input to any output.
REQ-017 CLOSED: door=1 -> OPEN; else start=1 and time_in!=0 -> COOK, remaining<=time_in, phase<=0; else stay; start with time_in==0 ignored.
REQ-018 COOK priority: door=1 -> PAUSE, remaining and phase held; else stop=1 -> CLOSED, remaining<=0; else remaining==1 -> BELL, remaining<=0, bell counter<=0; else remaining<=remaining-1, phase<=phase+1 mod 4.
REQ-019 PAUSE: stop=1 -> OPEN, remaining<=0; else door=0 -> COOK with remaining and phase unchanged; else stay.
REQ-020 BELL: door=1 -> OPEN; else bell counter==BELL_CYCLES-1 -> CLOSED; else bell counter increments.
REQ-021 OPEN: door=0 -> CLOSED; start and stop ignored.
REQ-022 bell = BELL; light = COOK|PAUSE|OPEN; busy = COOK|PAUSE.
REQ-023 heat = COOK and (phase <= power): power 3 continuous, 2 three of four cycles, 1 half, 0 one of four.
REQ-024 A COOK job loaded with N SHALL occupy exactly N cycles in COOK (excluding pause time) before entering BELL.
REQ-025 remaining SHALL never wrap below 0; time_in = 2^T_W-1 SHALL count correctly.
REQ-026 start asserted in COOK, PAUSE, BELL or OPEN SHALL have no effect (no reload).
REQ-027 start and stop both asserted in CLOSED: start wins if accepted per REQ-017.

Reset
REQ-028 nrst=0 SHALL force, immediately and regardless of clk, state=CLOSED, remaining=0, phase=0, bell counter=0, giving bell=0, light=0, heat=0, busy=0.
REQ-029 Reset asserted mid-COOK or mid-BELL SHALL abort the job; after release the block SHALL wait in CLOSED for a new start.

Verification
REQ-030 Reset, door=0, time_in=5, power=3, start pulse 1 cycle -> heat=1 and busy=1 for exactly 5 cycles, remaining 5,4,3,2,1, then bell=1 for 4 cycles, then CLOSED with all outputs 0.
REQ-031 time_in=8 started, door=1 after 3 COOK cycles for 4 cycles, then door=0 -> PAUSE with heat=0, light=1, remaining=5 held; resume completes after 5 further COOK cycles.
REQ-032 time_in=8, power=1 -> heat pattern 1,1,0,0,1,1,0,0 across the 8 COOK cycles; power=0 -> 1,0,0,0,1,0,0,0.
REQ-033 stop=1 in COOK with remaining=6 -> next cycle CLOSED, remaining=0, no bell; stop=1 in PAUSE -> OPEN, remaining=0.
REQ-034 door=1 during BELL cycle 2 -> OPEN next cycle, bell=0, light=1; start with time_in=0 in CLOSED -> no state change.
REQ-035 nrst pulsed low asynchronously between clock edges mid-COOK -> outputs 0 before next edge; T_W=4 with time_in=15 -> 15 COOK cycles, remaining never wraps.

Source files
------------

// File: rtl/microwave_timer.sv
// Microwave oven cook timer.
// One-hot control FSM (CLOSED/COOK/PAUSE/BELL/OPEN) with a cook-time
// countdown, a 2-bit duty phase for magnetron power levels and a bell
// duration counter. Every output decodes from registers only, so no
// input reaches an output combinationally.
module microwave_timer #(
  parameter int T_W         = 8,
  parameter int BELL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           door,
  input  logic           start,
  input  logic           stop,
  input  logic [T_W-1:0] time_in,
  input  logic [1:0]     power,
  output logic           bell,
  output logic           light,
  output logic           heat,
  output logic           busy,
  output logic [T_W-1:0] remaining
);

  localparam int BC_W = (BELL_CYCLES > 1) ? $clog2(BELL_CYCLES) : 1;
  localparam logic [BC_W-1:0] BELL_LAST = BC_W'(BELL_CYCLES - 1);
  localparam logic [T_W-1:0]  REM_ONE   = T_W'(1);

  typedef enum logic [4:0] {
    CLOSED = 5'b00001,
    COOK   = 5'b00010,
    PAUSE  = 5'b00100,
    BELL   = 5'b01000,
    OPEN   = 5'b10000
  } state_t;

  state_t          state, state_nxt;
  logic [T_W-1:0]  rem_q, rem_nxt;
  logic [1:0]      phase_q, phase_nxt;
  logic [BC_W-1:0] bcnt_q, bcnt_nxt;
  logic [1:0]      power_q;

  // Control state and counters; reset aborts any job and clears all of them.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= CLOSED;
      rem_q   <= '0;
      phase_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state   <= state_nxt;
      rem_q   <= rem_nxt;
      phase_q <= phase_nxt;
      bcnt_q  <= bcnt_nxt;
    end
  end

  // Power level sampled every cycle so heat decodes from a register; it only
  // matters while cooking, where the previous edge's sample is used.
  always_ff @(posedge clk) begin
    power_q <= power;
  end

  // Next-state and counter updates; door has priority over stop in COOK,
  // stop has priority over door in PAUSE.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_q;
    phase_nxt = phase_q;
    bcnt_nxt  = bcnt_q;
    unique case (state)
      CLOSED: begin
        if (door) begin
          state_nxt = OPEN;
        end else if (start && (time_in != '0)) begin
          state_nxt = COOK;
          rem_nxt   = time_in;
          phase_nxt = 2'd0;
        end
      end
      COOK: begin
        if (door) begin
          state_nxt = PAUSE;
        end else if (stop) begin
          state_nxt = CLOSED;
          rem_nxt   = '0;
        end else if (rem_q == REM_ONE) begin
          state_nxt = BELL;
          rem_nxt   = '0;
          bcnt_nxt  = '0;
        end else begin
          rem_nxt   = rem_q - REM_ONE;
          phase_nxt = phase_q + 2'd1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = OPEN;
          rem_nxt   = '0;
        end else if (!door) begin
          state_nxt = COOK;
        end
      end
      BELL: begin
        if (door) begin
          state_nxt = OPEN;
        end else if (bcnt_q == BELL_LAST) begin
          state_nxt = CLOSED;
        end else begin
          bcnt_nxt = bcnt_q + 1'b1;
        end
      end
      OPEN: begin
        if (!door) begin
          state_nxt = CLOSED;
        end
      end
      default: begin
        state_nxt = CLOSED;
        rem_nxt   = '0;
        phase_nxt = 2'd0;
        bcnt_nxt  = '0;
      end
    endcase
  end

  assign bell      = (state == BELL);
  assign light     = (state == COOK) || (state == PAUSE) || (state == OPEN);
  assign busy      = (state == COOK) || (state == PAUSE);
  // phase <= power gives duty 1/4, 2/4, 3/4, 4/4 for power 0..3.
  assign heat      = (state == COOK) && (phase_q <= power_q);
  assign remaining = rem_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: expected outputs are queued as each cycle of
// stimulus is driven and compared one cycle later by a monitor process.
module tb_microwave_timer;

  logic       clk = 1'b0;
  logic       nrst, door, start, stop;
  logic [7:0] time_in;
  logic [1:0] power;
  logic       bell, light, heat, busy;
  logic [7:0] remaining;
  logic [3:0] time_in4;
  logic       bell4, light4, heat4, busy4;
  logic [3:0] remaining4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       sel;
    logic       bell;
    logic       light;
    logic       heat;
    logic       busy;
    logic [7:0] rem;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  microwave_timer #(.T_W(8), .BELL_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst), .door(door), .start(start), .stop(stop),
    .time_in(time_in), .power(power), .bell(bell), .light(light),
    .heat(heat), .busy(busy), .remaining(remaining)
  );

  microwave_timer #(.T_W(4), .BELL_CYCLES(4)) dut4 (
    .clk(clk), .nrst(nrst), .door(door), .start(start), .stop(stop),
    .time_in(time_in4), .power(power), .bell(bell4), .light(light4),
    .heat(heat4), .busy(busy4), .remaining(remaining4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t mk(logic s, logic b, logic l, logic h, logic bz, logic [7:0] r);
    exp_t e;
    e.sel = s; e.bell = b; e.light = l; e.heat = h; e.busy = bz; e.rem = r;
    return e;
  endfunction

  function automatic exp_t e_cook(logic h, logic [7:0] r);  return mk(0, 0, 1, h, 1, r); endfunction
  function automatic exp_t e_pause(logic [7:0] r);          return mk(0, 0, 1, 0, 1, r); endfunction
  function automatic exp_t e_bell();                        return mk(0, 1, 0, 0, 0, 0); endfunction
  function automatic exp_t e_open();                        return mk(0, 0, 1, 0, 0, 0); endfunction
  function automatic exp_t e_idle();                        return mk(0, 0, 0, 0, 0, 0); endfunction

  // Monitor: one queued expectation per clock, sampled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.sel == 1'b0) begin
          check("bell", bell, e.bell);
          check("light", light, e.light);
          check("heat", heat, e.heat);
          check("busy", busy, e.busy);
          check("remaining", remaining, e.rem);
        end else begin
          check("bell4", bell4, e.bell);
          check("light4", light4, e.light);
          check("heat4", heat4, e.heat);
          check("busy4", busy4, e.busy);
          check("remaining4", {4'b0, remaining4}, e.rem);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue what the outputs must show after the edge.
  task automatic step(input logic d, input logic st, input logic sp,
                      input logic [7:0] t, input logic [1:0] pw, input exp_t e);
    door = d; start = st; stop = sp; time_in = t; power = pw;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run_bell(input logic s);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e = e_bell(); e.sel = s;
      step(0, 0, 0, 0, 3, e);
    end
    e = e_idle(); e.sel = s;
    step(0, 0, 0, 0, 3, e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bell"}, bell, 0);
    check({tag, "_light"}, light, 0);
    check({tag, "_heat"}, heat, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rem"}, remaining, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pats [3];
    logic [1:0] pws  [3];
    logic [7:0] pat;
    exp_t e;

    nrst = 1'b0; door = 0; start = 0; stop = 0; time_in = '0; time_in4 = '0; power = 2'd3;
    #1;
    check_zero("reset");
    @(negedge clk);
    nrst = 1'b1;

    // Basic job: 5 cycles at full power, then 4 bell cycles.
    step(0, 1, 0, 5, 3, e_cook(1, 5));
    for (int r = 4; r >= 1; r--) step(0, 0, 0, 5, 3, e_cook(1, r[7:0]));
    run_bell(0);

    // Door pause mid-job with remaining held; start during pause ignored.
    step(0, 1, 0, 8, 3, e_cook(1, 8));
    for (int r = 7; r >= 5; r--) step(0, 0, 0, 8, 3, e_cook(1, r[7:0]));
    for (int k = 0; k < 4; k++) step(1, (k == 1), 0, 20, 3, e_pause(5));
    step(0, 0, 0, 8, 3, e_cook(1, 5));
    for (int r = 4; r >= 1; r--) step(0, 0, 0, 8, 3, e_cook(1, r[7:0]));
    run_bell(0);

    // Duty patterns for power 1, 0, 2 over an 8-cycle job (MSB first).
    pats[0] = 8'b1100_1100; pws[0] = 2'd1;
    pats[1] = 8'b1000_1000; pws[1] = 2'd0;
    pats[2] = 8'b1110_1110; pws[2] = 2'd2;
    for (int p = 0; p < 3; p++) begin
      pat = pats[p];
      step(0, 1, 0, 8, pws[p], e_cook(pat[7], 8));
      for (int i = 1; i < 8; i++) step(0, 0, 0, 8, pws[p], e_cook(pat[7-i], 8'(8 - i)));
      run_bell(0);
    end

    // Stop in COOK at remaining 6: straight to CLOSED, no bell.
    step(0, 1, 0, 9, 3, e_cook(1, 9));
    for (int r = 8; r >= 6; r--) step(0, 0, 0, 9, 3, e_cook(1, r[7:0]));
    step(0, 0, 1, 9, 3, e_idle());
    step(0, 0, 0, 9, 3, e_idle());
    step(0, 0, 0, 9, 3, e_idle());

    // Stop in PAUSE: to OPEN with remaining cleared.
    step(0, 1, 0, 9, 3, e_cook(1, 9));
    step(1, 0, 0, 9, 3, e_pause(9));
    step(1, 0, 1, 9, 3, e_open());
    step(0, 0, 0, 9, 3, e_idle());

    // Start and stop together in CLOSED: start wins. Held start never reloads.
    step(0, 1, 1, 3, 3, e_cook(1, 3));
    step(0, 1, 0, 7, 3, e_cook(1, 2));
    step(0, 1, 0, 7, 3, e_cook(1, 1));
    step(0, 1, 0, 7, 3, e_bell());
    step(0, 0, 0, 7, 3, e_bell());
    // Door during bell cycle 2 goes to OPEN; start is ignored in OPEN.
    step(1, 0, 0, 7, 3, e_open());
    step(1, 1, 0, 5, 3, e_open());
    step(0, 0, 0, 5, 3, e_idle());
    // Zero cook time is not accepted.
    step(0, 1, 0, 0, 3, e_idle());
    step(0, 1, 0, 0, 3, e_idle());
    step(0, 0, 0, 0, 3, e_idle());

    // Asynchronous reset between edges mid-COOK.
    step(0, 1, 0, 6, 3, e_cook(1, 6));
    step(0, 0, 0, 6, 3, e_cook(1, 5));
    nrst = 1'b0;
    #1;
    check_zero("async_rst_cook");
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    step(0, 0, 0, 6, 3, e_idle());
    step(0, 0, 0, 6, 3, e_idle());

    // Reset mid-BELL aborts the bell.
    step(0, 1, 0, 1, 3, e_cook(1, 1));
    step(0, 0, 0, 1, 3, e_bell());
    nrst = 1'b0;
    #1;
    check_zero("async_rst_bell");
    @(negedge clk);
    nrst = 1'b1;
    step(0, 0, 0, 1, 3, e_idle());

    // Narrow counter: T_W=4 loaded with 15 counts all the way down.
    time_in4 = 4'd15;
    e = e_cook(1, 15); e.sel = 1'b1;
    step(0, 1, 0, 0, 3, e);
    time_in4 = 4'd0;
    for (int r = 14; r >= 1; r--) begin
      e = e_cook(1, r[7:0]); e.sel = 1'b1;
      step(0, 0, 0, 0, 3, e);
    end
    run_bell(1);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
